// File: rtl/sha_msg_padder_if.sv
// Stream-in / block-out bundle for sha_msg_padder: 32-bit message words in, 512-bit padded blocks out.
// master = message source / block consumer side, slave = the padder.
interface sha_msg_padder_if;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [1:0]   s_bytes;
  logic         blk_valid;
  logic         blk_redo;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         err;

  modport master (
    output s_valid, s_data, s_last, s_bytes,
    input  s_ready, blk_valid, blk_redo, blk_data, blk_last, err
  );

  modport slave (
    input  s_valid, s_data, s_last, s_bytes,
    output s_ready, blk_valid, blk_redo, blk_data, blk_last, err
  );
endinterface

// File: rtl/sha_msg_padder.sv
// FIPS 180-4 message padder feeding the SHA-256 round core with 64-cycle chained block issue.
// Optional macro SHA_PAD_OVERRUN_EN: flag and drop messages whose continuation block misses its slot.
module sha_msg_padder (
  input  logic             clk,
  input  logic             reset_n,
  sha_msg_padder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_PADW = 3'd2,
    S_WAIT = 3'd3,
    S_DROP = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [0:15][31:0]  buf_q;
  logic [3:0]         idx_q, idx_d;
  logic [60:0]        cnt_q, cnt_d;
  logic [6:0]         slot_q, slot_d;
  logic               need_mark_q, need_mark_d;
  logic               late_q, late_d;
  logic               fin_q, fin_d;
  logic               cont_q, cont_d;
  logic               blk_valid_q;
  logic               blk_last_q;
  logic [511:0]       blk_data_q;

  logic               s_ready_s;
  logic               accept_s;
  logic               issue_s;
  logic               issue_ok_s;
  logic               wr_s;
  logic [31:0]        wr_data_s;
  logic [2:0]         nbytes_s;
  logic [63:0]        len_s;

  // Final word: keep the valid bytes, append the 0x80 marker, zero everything after it.
  function automatic logic [31:0] mark_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
    logic [31:0] w;
    w = d;
    if (last) begin
      case (nb)
        2'd1:    w = {d[31:24], 24'h800000};
        2'd2:    w = {d[31:16], 16'h8000};
        2'd3:    w = {d[31:8],  8'h80};
        default: w = d;
      endcase
    end else begin
      w = d;
    end
    return w;
  endfunction

  assign s_ready_s  = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_DROP);
  assign accept_s   = bus.s_valid && s_ready_s;
  assign nbytes_s   = (bus.s_last && (bus.s_bytes != 2'd0)) ? {1'b0, bus.s_bytes} : 3'd4;
  assign len_s      = {cnt_q, 3'b000};
  // A chained block must go exactly on slot 63; anything else waits for the IV-restart window.
  assign issue_ok_s = (slot_q >= 7'd64) || (cont_q && (slot_q == 7'd63));

`ifdef SHA_PAD_OVERRUN_EN
  logic err_q, err_d;
`endif

  // Next-state, buffer write and issue decision.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    need_mark_d = need_mark_q;
    late_d      = late_q;
    fin_d       = fin_q;
    cont_d      = cont_q;
    wr_s        = 1'b0;
    wr_data_s   = 32'h0000_0000;
    issue_s     = 1'b0;
`ifdef SHA_PAD_OVERRUN_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept_s) begin
          wr_s      = 1'b1;
          wr_data_s = mark_word(bus.s_data, bus.s_last, bus.s_bytes);
          cnt_d     = ((state_q == S_IDLE) ? 61'd0 : cnt_q) + 61'(nbytes_s);
          idx_d     = idx_q + 4'd1;
          if (bus.s_last) begin
            if (bus.s_bytes == 2'd0) begin
              need_mark_d = 1'b1;
            end else begin
              late_d = (idx_q >= 4'd14);
            end
            state_d = (idx_q == 4'd15) ? S_WAIT : S_PADW;
          end else begin
            state_d = (idx_q == 4'd15) ? S_WAIT : S_FILL;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_PADW: begin
        wr_s  = 1'b1;
        idx_d = idx_q + 4'd1;
        if (need_mark_q) begin
          wr_data_s   = 32'h8000_0000;
          need_mark_d = 1'b0;
          late_d      = (idx_q >= 4'd14);
        end else if (!late_q && (idx_q == 4'd14)) begin
          wr_data_s = len_s[63:32];
        end else if (!late_q && (idx_q == 4'd15)) begin
          wr_data_s = len_s[31:0];
          fin_d     = 1'b1;
        end else begin
          wr_data_s = 32'h0000_0000;
        end
        state_d = (idx_q == 4'd15) ? S_WAIT : S_PADW;
      end
      S_WAIT: begin
        if (issue_ok_s) begin
          issue_s = 1'b1;
          idx_d   = 4'd0;
          if (fin_q) begin
            fin_d   = 1'b0;
            cont_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            // A marker that spilled into words 14/15 still owes a length-only block.
            cont_d  = 1'b1;
            late_d  = 1'b0;
            state_d = (need_mark_q || late_q) ? S_PADW : S_FILL;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (accept_s && bus.s_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef SHA_PAD_OVERRUN_EN
    if (cont_q && (slot_q == 7'd63) && (state_q != S_WAIT)) begin
      err_d       = 1'b1;
      cont_d      = 1'b0;
      need_mark_d = 1'b0;
      late_d      = 1'b0;
      fin_d       = 1'b0;
      idx_d       = 4'd0;
      state_d     = ((state_q == S_FILL) && !(accept_s && bus.s_last)) ? S_DROP : S_IDLE;
    end else begin
      err_d = err_q;
    end
`endif
  end

  // Slot counter: restarts on every issue, saturates so an idle core allows an immediate issue.
  always_comb begin
    slot_d = slot_q;
    if (issue_s) begin
      slot_d = 7'd0;
    end else if (slot_q == 7'd127) begin
      slot_d = slot_q;
    end else begin
      slot_d = slot_q + 7'd1;
    end
  end

  // State, control and fill-buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      idx_q       <= 4'd0;
      cnt_q       <= 61'd0;
      slot_q      <= 7'd127;
      need_mark_q <= 1'b0;
      late_q      <= 1'b0;
      fin_q       <= 1'b0;
      cont_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      need_mark_q <= need_mark_d;
      late_q      <= late_d;
      fin_q       <= fin_d;
      cont_q      <= cont_d;
      if (wr_s) begin
        buf_q[idx_q] <= wr_data_s;
      end else begin
        buf_q <= buf_q;
      end
    end
  end

  // Output block register, loaded only on issue so the core sees a stable message.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      blk_data_q  <= 512'd0;
    end else begin
      blk_valid_q <= issue_s;
      blk_last_q  <= issue_s && fin_q;
      if (issue_s) begin
        blk_data_q <= buf_q;
      end else begin
        blk_data_q <= blk_data_q;
      end
    end
  end

`ifdef SHA_PAD_OVERRUN_EN
  // Sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.s_ready   = s_ready_s;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_redo  = 1'b0;

endmodule
